// File: rtl/led_chain_driver_if.sv
// rtl/led_chain_driver_if.sv - pixel memory read port between frame buffer and LED chain driver
interface led_chain_driver_if #(
  parameter int P_CHIPS = 4,
  parameter int P_BITS  = 16
);
  localparam int W_ADDR = (P_CHIPS > 1) ? $clog2(P_CHIPS) : 1;

  logic                  o_rd_en;
  logic [W_ADDR-1:0]     o_rd_addr;
  logic [4*P_BITS-1:0]   i_rd_data;

  modport master (output o_rd_en, output o_rd_addr, input i_rd_data);
  modport slave  (input o_rd_en, input o_rd_addr, output i_rd_data);
endinterface

// File: rtl/led_chain_driver.sv
// rtl/led_chain_driver.sv - serial LED chain frame engine (clock/data/latch), farthest chip first
// Optional internal test-pattern generator: define LED_TEST_PATTERN_EN.
module led_chain_driver #(
  parameter int P_CHIPS        = 4,
  parameter int P_BITS         = 16,
  parameter int P_CLKDIV       = 2,
  parameter int P_FRAME_PERIOD = 16666,
  parameter int P_FRAME_MAX    = 120,
  parameter int P_LATCH_CYCLES = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  led_chain_driver_if.master             pix,
  input  logic                           i_test,
  output logic                           o_clk,
  output logic                           o_dai,
  output logic                           o_lat,
  output logic                           o_busy,
  output logic                           o_frame_start,
  output logic [$clog2(P_FRAME_MAX)-1:0] o_frame_cnt,
  output logic                           o_overrun
);
  localparam int W_ADDR = (P_CHIPS > 1) ? $clog2(P_CHIPS) : 1;
  localparam int W_WORD = 4 * P_BITS;
  localparam int W_BCNT = $clog2(W_WORD + 1);
  localparam int W_DIV  = (P_CLKDIV > 1) ? $clog2(P_CLKDIV) : 1;
  localparam int W_LAT  = (P_LATCH_CYCLES > 1) ? $clog2(P_LATCH_CYCLES) : 1;
  localparam int W_TMR  = (P_FRAME_PERIOD > 1) ? $clog2(P_FRAME_PERIOD) : 1;
  localparam int W_FCNT = $clog2(P_FRAME_MAX);

  localparam logic [W_ADDR-1:0] CHIP_LAST = W_ADDR'(P_CHIPS - 1);
  localparam logic [W_BCNT-1:0] BCNT_FULL = W_BCNT'(W_WORD);
  localparam logic [W_BCNT-1:0] BCNT_ONE  = W_BCNT'(1);
  localparam logic [W_DIV-1:0]  DIV_LAST  = W_DIV'(P_CLKDIV - 1);
  localparam logic [W_LAT-1:0]  LAT_LAST  = W_LAT'(P_LATCH_CYCLES - 1);
  localparam logic [W_TMR-1:0]  TMR_LAST  = W_TMR'(P_FRAME_PERIOD - 1);
  localparam logic [W_FCNT-1:0] FCNT_LAST = W_FCNT'(P_FRAME_MAX - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_SHIFT, S_LATCH} state_t;

  state_t            state, state_d;
  logic [W_TMR-1:0]  tmr;
  logic              tick;
  logic [W_ADDR-1:0] chip, chip_d, rd_addr_d;
  logic [W_WORD-2:0] shreg, shreg_d;
  logic [W_BCNT-1:0] bcnt, bcnt_d;
  logic [W_DIV-1:0]  div, div_d;
  logic [W_LAT-1:0]  lcnt, lcnt_d;
  logic              rd_en_d, clk_d, dai_d, lat_d, busy_d, fstart_d, overrun_d;
  logic              pat_now;
  logic [W_WORD-1:0] load_word;

  assign tick = (tmr == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmr         <= '0;
      o_frame_cnt <= '0;
    end else if (tmr == TMR_LAST) begin
      tmr         <= '0;
      o_frame_cnt <= (o_frame_cnt == FCNT_LAST) ? '0 : o_frame_cnt + 1'b1;
    end else begin
      tmr <= tmr + 1'b1;
    end
  end

`ifdef LED_TEST_PATTERN_EN
  localparam int QUARTER = P_FRAME_MAX / 4;
  logic              test_q;
  logic [W_FCNT-1:0] fcl;
  logic [W_WORD-1:0] pat_word;

  // Mode and frame index are frozen at frame start so a frame never mixes sources.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      test_q <= 1'b0;
      fcl    <= '0;
    end else if (state == S_IDLE && tick) begin
      test_q <= i_test;
      fcl    <= o_frame_cnt;
    end
  end

  always_comb begin
    pat_word = '0;
    if (int'(fcl) < QUARTER)          pat_word[4*P_BITS-1 -: P_BITS] = '1;
    else if (int'(fcl) < 2 * QUARTER) pat_word[3*P_BITS-1 -: P_BITS] = '1;
    else if (int'(fcl) < 3 * QUARTER) pat_word[2*P_BITS-1 -: P_BITS] = '1;
    else                              pat_word[P_BITS-1:0]           = '1;
  end

  assign pat_now   = (state == S_IDLE) ? i_test : test_q;
  assign load_word = test_q ? pat_word : pix.i_rd_data;
`else
  logic unused_test;
  assign unused_test = i_test;
  assign pat_now     = 1'b0;
  assign load_word   = pix.i_rd_data;
`endif

  always_comb begin
    state_d   = state;
    chip_d    = chip;
    shreg_d   = shreg;
    bcnt_d    = bcnt;
    div_d     = div;
    lcnt_d    = lcnt;
    rd_en_d   = 1'b0;
    rd_addr_d = pix.o_rd_addr;
    clk_d     = o_clk;
    dai_d     = o_dai;
    lat_d     = 1'b0;
    busy_d    = o_busy;
    fstart_d  = 1'b0;
    overrun_d = o_overrun | (tick && state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (tick) begin
          state_d   = S_FETCH;
          fstart_d  = 1'b1;
          busy_d    = 1'b1;
          chip_d    = CHIP_LAST;
          rd_addr_d = CHIP_LAST;
          rd_en_d   = !pat_now;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        // First bit is presented immediately; shreg holds the bits behind it.
        dai_d   = load_word[W_WORD-1];
        shreg_d = load_word[W_WORD-2:0];
        bcnt_d  = BCNT_FULL;
        div_d   = '0;
        clk_d   = 1'b0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (div == DIV_LAST) begin
          div_d = '0;
          if (!o_clk) begin
            clk_d = 1'b1;
          end else begin
            clk_d   = 1'b0;
            bcnt_d  = bcnt - 1'b1;
            shreg_d = {shreg[W_WORD-3:0], 1'b0};
            if (bcnt == BCNT_ONE) begin
              dai_d = 1'b0;
              if (chip != '0) begin
                chip_d    = chip - 1'b1;
                rd_addr_d = chip - 1'b1;
                rd_en_d   = !pat_now;
                state_d   = S_FETCH;
              end else begin
                lat_d   = 1'b1;
                lcnt_d  = '0;
                state_d = S_LATCH;
              end
            end else begin
              dai_d = shreg[W_WORD-2];
            end
          end
        end else begin
          div_d = div + 1'b1;
        end
      end
      S_LATCH: begin
        clk_d = 1'b0;
        dai_d = 1'b0;
        if (lcnt == LAT_LAST) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          lat_d  = 1'b1;
          lcnt_d = lcnt + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      chip          <= '0;
      shreg         <= '0;
      bcnt          <= '0;
      div           <= '0;
      lcnt          <= '0;
      pix.o_rd_en   <= 1'b0;
      pix.o_rd_addr <= '0;
      o_clk         <= 1'b0;
      o_dai         <= 1'b0;
      o_lat         <= 1'b0;
      o_busy        <= 1'b0;
      o_frame_start <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      state         <= state_d;
      chip          <= chip_d;
      shreg         <= shreg_d;
      bcnt          <= bcnt_d;
      div           <= div_d;
      lcnt          <= lcnt_d;
      pix.o_rd_en   <= rd_en_d;
      pix.o_rd_addr <= rd_addr_d;
      o_clk         <= clk_d;
      o_dai         <= dai_d;
      o_lat         <= lat_d;
      o_busy        <= busy_d;
      o_frame_start <= fstart_d;
      o_overrun     <= overrun_d;
    end
  end
endmodule

// File: tb/tb_led_chain_driver.sv
// tb/tb_led_chain_driver.sv - directed scoreboard bench for led_chain_driver (two chain configurations)
module tb_led_chain_driver;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, rst_b = 1'b0, test_a = 1'b0, test_b = 1'b0;
  logic a_clk, a_dai, a_lat, a_busy, a_fs, a_ovr;
  logic b_clk, b_dai, b_lat, b_busy, b_fs, b_ovr;
  logic [1:0] a_fc, b_fc;

  led_chain_driver_if #(.P_CHIPS(2), .P_BITS(4)) pa ();
  led_chain_driver_if #(.P_CHIPS(2), .P_BITS(4)) pb ();

  led_chain_driver #(.P_CHIPS(2), .P_BITS(4), .P_CLKDIV(1), .P_FRAME_PERIOD(200),
                     .P_FRAME_MAX(4), .P_LATCH_CYCLES(4)) dut_a (
    .i_clk(clk), .i_rst_n(rst_a), .pix(pa), .i_test(test_a),
    .o_clk(a_clk), .o_dai(a_dai), .o_lat(a_lat), .o_busy(a_busy),
    .o_frame_start(a_fs), .o_frame_cnt(a_fc), .o_overrun(a_ovr));

  led_chain_driver #(.P_CHIPS(2), .P_BITS(4), .P_CLKDIV(3), .P_FRAME_PERIOD(50),
                     .P_FRAME_MAX(4), .P_LATCH_CYCLES(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_b), .pix(pb), .i_test(test_b),
    .o_clk(b_clk), .o_dai(b_dai), .o_lat(b_lat), .o_busy(b_busy),
    .o_frame_start(b_fs), .o_frame_cnt(b_fc), .o_overrun(b_ovr));

  logic [15:0] mem_a [2];
  logic [15:0] mem_b [2];
  always @(posedge clk) if (pa.o_rd_en) pa.i_rd_data <= mem_a[pa.o_rd_addr];
  always @(posedge clk) if (pb.o_rd_en) pb.i_rd_data <= mem_b[pb.o_rd_addr];

  bit qa[$];
  bit qb[$];
  bit qaddr_a[$];
  bit qaddr_b[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] w, input bit to_b);
    for (int i = 15; i >= 0; i--) begin
      if (to_b) qb.push_back(w[i]);
      else      qa.push_back(w[i]);
    end
  endtask

  // Chain monitor A: pops expected bits on rising o_clk, tracks latch width and reads.
  logic pclk_a = 1'b0, plat_a = 1'b0;
  int edges_a = 0, latrun_a = 0, fs_a = 0;
  always @(negedge clk) begin
    if (rst_a) begin
      if (a_clk && !pclk_a) begin
        edges_a++;
        if (qa.size() == 0) check("dai_a_unexpected_edge", 1, 0);
        else                check("dai_a", a_dai, qa.pop_front());
      end
      if (a_lat) begin
        latrun_a++;
        check("lat_while_clk_a", a_clk, 0);
      end else if (plat_a) begin
        check("lat_width_a", latrun_a, 4);
        latrun_a = 0;
      end
      if (pa.o_rd_en) begin
        if (qaddr_a.size() == 0) check("rd_en_unexpected_a", 1, 0);
        else                     check("rd_addr_a", pa.o_rd_addr, qaddr_a.pop_front());
      end
      if (a_fs) begin
        fs_a++;
        edges_a = 0;
      end
    end else begin
      latrun_a = 0;
    end
    pclk_a = a_clk;
    plat_a = a_lat;
  end

  // Chain monitor B: adds clock-shape and data-stability checks for the divided clock.
  logic pclk_b = 1'b0, plat_b = 1'b0, pdai_b = 1'b0;
  int edges_b = 0, latrun_b = 0, run_b = 0;
  always @(negedge clk) begin
    if (rst_b) begin
      if (b_clk != pclk_b) begin
        if (b_clk) begin
          edges_b++;
          check("clk_low_b", (run_b >= 3) ? 1 : 0, 1);
          check("dai_stable_b", b_dai, pdai_b);
          if (qb.size() == 0) check("dai_b_unexpected_edge", 1, 0);
          else                check("dai_b", b_dai, qb.pop_front());
        end else begin
          check("clk_high_b", run_b, 3);
        end
        run_b = 1;
      end else begin
        run_b++;
      end
      if (b_lat) begin
        latrun_b++;
        check("lat_while_clk_b", b_clk, 0);
      end else if (plat_b) begin
        check("lat_width_b", latrun_b, 4);
        latrun_b = 0;
      end
      if (pb.o_rd_en) begin
        if (qaddr_b.size() == 0) check("rd_en_unexpected_b", 1, 0);
        else                     check("rd_addr_b", pb.o_rd_addr, qaddr_b.pop_front());
      end
      if (b_fs) edges_b = 0;
    end else begin
      latrun_b = 0;
      run_b    = 0;
    end
    pclk_b = b_clk;
    plat_b = b_lat;
    pdai_b = b_dai;
  end

  task automatic run_frame_a(input logic [15:0] w1, input logic [15:0] w0,
                             input int exp_cnt, input bit rd);
    bit got;
    push_word(w1, 1'b0);
    push_word(w0, 1'b0);
    if (rd) begin
      qaddr_a.push_back(1'b1);
      qaddr_a.push_back(1'b0);
    end
    fs_a = 0;
    got  = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (a_fs) got = 1'b1;
    end
    if (!got) begin
      check("frame_start_wait_a", 0, 1);
    end else begin
      check("frame_cnt_a", a_fc, exp_cnt);
      check("busy_rise_a", a_busy, 1);
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
        @(negedge clk);
        if (!a_busy) got = 1'b1;
      end
      check("busy_fall_a", got, 1);
      check("edges_per_frame_a", edges_a, 32);
      check("frame_start_once_a", fs_a, 1);
    end
  endtask

  initial begin
    bit got;
    mem_a[1] = 16'hA5C3;
    mem_a[0] = 16'h0F01;
    mem_b[1] = 16'h1234;
    mem_b[0] = 16'hFEDC;
    repeat (5) @(negedge clk);
    check("rst_clk_a",     a_clk, 0);
    check("rst_dai_a",     a_dai, 0);
    check("rst_lat_a",     a_lat, 0);
    check("rst_busy_a",    a_busy, 0);
    check("rst_fs_a",      a_fs, 0);
    check("rst_ovr_a",     a_ovr, 0);
    check("rst_fc_a",      a_fc, 0);
    check("rst_rd_en_a",   pa.o_rd_en, 0);
    check("rst_rd_addr_a", pa.o_rd_addr, 0);
    rst_a = 1'b1;

    for (int k = 0; k < 9; k++) run_frame_a(mem_a[1], mem_a[0], k % 4, 1'b1);
    check("overrun_clear_a", a_ovr, 0);
    check("queue_drained_a", qa.size(), 0);
    check("addr_drained_a", qaddr_a.size(), 0);

`ifdef LED_TEST_PATTERN_EN
    test_a = 1'b1;
    run_frame_a(16'h0F00, 16'h0F00, 1, 1'b0);
    run_frame_a(16'h00F0, 16'h00F0, 2, 1'b0);
    run_frame_a(16'h000F, 16'h000F, 3, 1'b0);
    run_frame_a(16'hF000, 16'hF000, 0, 1'b0);
    test_a = 1'b0;
`endif
    rst_a = 1'b0;

    for (int f = 0; f < 2; f++) begin
      push_word(mem_b[1], 1'b1);
      push_word(mem_b[0], 1'b1);
      qaddr_b.push_back(1'b1);
      qaddr_b.push_back(1'b0);
    end
    @(negedge clk);
    rst_b = 1'b1;

    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (b_ovr) got = 1'b1;
    end
    check("overrun_set_b", got, 1);
    check("busy_at_overrun_b", b_busy, 1);

    got = 1'b0;
    for (int i = 0; i < 800 && !got; i++) begin
      @(negedge clk);
      if (!b_busy) got = 1'b1;
    end
    check("busy_fall_b", got, 1);
    check("edges_per_frame_b", edges_b, 32);
    check("queue_left_b", qb.size(), 32);
    check("overrun_sticky_b", b_ovr, 1);

    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (b_fs) got = 1'b1;
    end
    check("frame_start_b", got, 1);
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (b_clk && edges_b >= 5) got = 1'b1;
    end
    check("mid_shift_reached_b", got, 1);
    rst_b = 1'b0;
    #1;
    check("mid_rst_clk_b",  b_clk, 0);
    check("mid_rst_dai_b",  b_dai, 0);
    check("mid_rst_lat_b",  b_lat, 0);
    check("mid_rst_busy_b", b_busy, 0);
    check("mid_rst_ovr_b",  b_ovr, 0);
    qb.delete();
    qaddr_b.delete();
    repeat (10) @(negedge clk);
    check("no_latch_after_abort_b", b_lat, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/led_chain_driver.md
Name: led_chain_driver

Overview:
- Parametrised serial LED-driver frame engine.
- Once per frame period it reads one pixel word per chip from a pixel memory and shifts the data out on a clock/data/latch chain. Each pixel word holds 4 channels: white, blue, green, red.
- It then pulses latch.
- Sits between the frame buffer and the LED chain pins. Chain length, grey-scale depth, serial clock rate and frame timing are generalised.

Parameters:
- P_CHIPS, 4, number of driver chips in the chain (>=1).
- P_BITS, 16, bits per channel (>=2).
- P_CLKDIV, 2, i_clk cycles per o_clk half-period (>=1).
- P_FRAME_PERIOD, 16666, i_clk cycles per frame.
- P_FRAME_MAX, 120, frame counter modulus; must be a multiple of 4.
- P_LATCH_CYCLES, 4, o_lat high width in i_clk cycles (>=1).

Ports:
- i_clk, in, 1, system clock.
- i_rst_n, in, 1, asynchronous active-low reset.
- o_rd_en, out, 1, pixel read strobe.
- o_rd_addr, out, $clog2(P_CHIPS) (min 1), chip index being read.
- i_rd_data, in, 4*P_BITS, pixel word {W,B,G,R}, W in MSBs; valid exactly 1 cycle after o_rd_en.
- i_test, in, 1, test-pattern select (see Optional Feature).
- o_clk, out, 1, serial clock to chain.
- o_dai, out, 1, serial data to chain.
- o_lat, out, 1, latch to chain.
- o_busy, out, 1, high from frame start until latch completes.
- o_frame_start, out, 1, one-cycle pulse when a frame transfer begins.
- o_frame_cnt, out, $clog2(P_FRAME_MAX), current frame index.
- o_overrun, out, 1, sticky: a frame tick arrived while busy.

Behaviour:
- Reset (async, i_rst_n=0): all outputs 0, counters 0, FSM in IDLE. Reset asserted mid-shift aborts the transfer immediately; no latch is issued.
- Frame timer: counts 0..P_FRAME_PERIOD-1 and wraps. Tick = count==0.
- o_frame_cnt: increments on each wrap of the frame timer, 0..P_FRAME_MAX-1, then wraps to 0.
- IDLE: on tick go to FETCH, pulse o_frame_start, raise o_busy. Chip index = P_CHIPS-1, so the farthest chip is sent first.
- FETCH: o_rd_en=1 for exactly one cycle with o_rd_addr = chip index. Next state: LOAD.
- LOAD: capture i_rd_data into the shift register. Bit counter = 4*P_BITS. Next state: SHIFT.
- SHIFT: shift order per chip is W, B, G, R, each MSB first.
  - Per bit, o_dai changes while o_clk is low.
  - o_clk stays low for P_CLKDIV cycles, then high for P_CLKDIV cycles; the chain samples on the rising edge.
  - After the last bit of a chip, o_clk returns low.
  - If chip index > 0: decrement it and go to FETCH.
  - Otherwise go to LATCH.
- LATCH: o_clk=0, o_dai=0, o_lat=1 for P_LATCH_CYCLES cycles. Then IDLE, o_busy=0.
- One full frame shifts exactly P_CHIPS*4*P_BITS o_clk rising edges.
- Overrun: a tick while not in IDLE sets o_overrun (cleared only by reset). That frame is skipped; the current transfer completes unaffected.
- o_clk and o_dai idle low. o_lat is never high while o_clk is high.
- All outputs are registered.

Optional Feature:
- Macro: LED_TEST_PATTERN_EN.
- Defined, i_test=1:
  - LOAD uses an internal word instead of i_rd_data, and o_rd_en stays 0.
  - The word holds one channel at all-ones, others 0, identical for all chips.
  - Channel chosen from o_frame_cnt latched at frame start: first quarter of P_FRAME_MAX = white, second = blue, third = green, fourth = red.
- Defined, i_test=0: normal memory-read behaviour.
- Not defined: i_test is ignored and the generator logic is absent.

Test Plan:
- Reset/idle (P_CHIPS=2, P_BITS=4, P_CLKDIV=1, P_FRAME_PERIOD=200, P_FRAME_MAX=4): hold i_rst_n=0 for 5 cycles, release -> all outputs 0. First frame: o_frame_start pulses once, o_busy rises.
- Data order: memory addr1=16'hA5C3, addr0=16'h0F01 -> o_rd_addr sequence 1 then 0. o_dai sampled on rising o_clk = 1010 0101 1100 0011 0000 1111 0000 0001. Then o_lat high exactly 4 cycles.
- Clock shape: P_CLKDIV=3 -> each o_clk half-period is 3 i_clk cycles. 32 rising edges per frame. o_dai stable at every rising edge.
- Frame counter: run 9 frames -> o_frame_cnt sequence 0,1,2,3,0,1,2,3,0. o_overrun stays 0.
- Overrun: P_FRAME_PERIOD=50 with the above chain -> o_overrun=1 after the first period. No o_lat pulse appears while o_clk=1. Assert i_rst_n=0 mid-shift -> o_clk, o_dai, o_lat, o_busy drop immediately.
- LED_TEST_PATTERN_EN defined, i_test=1, P_FRAME_MAX=8:
  - Frames 0-1 shift 16'hF000 per chip; frames 2-3 16'h0F00; frames 4-5 16'h00F0; frames 6-7 16'h000F.
  - o_rd_en never asserted.
